// File: rtl/tpu_layer_sequencer.sv
// Layer sequencer for the TPU top controller: queues layer commands and runs each one
// through a clear / start / done handshake, with an optional RUN-phase timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a queued command; pops the FIFO head on exit
// LOAD     | active command latched, stage enables asserted
// CLR      | one-cycle tpu_reset to clear the controller's sticky done
// RUN      | start_tpu held, waiting for done_tpu or the timeout
// COMPLETE | layer_done (and seq_done for the last layer) pulse
// ERROR    | timeout hit; FIFO flushed, held here until reset
module tpu_layer_sequencer #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_en,
    input  logic [ID_W-1:0]  cmd_id,
    input  logic             cmd_last,
    input  logic [TMO_W-1:0] timeout_limit,
    output logic             tpu_reset,
    output logic             start_tpu,
    output logic             enable_matmul,
    output logic             enable_norm,
    output logic             enable_pool,
    output logic             enable_activation,
    input  logic             done_tpu,
    output logic             busy,
    output logic             layer_done,
    output logic [ID_W-1:0]  layer_done_id,
    output logic             seq_done,
    output logic             timeout_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 3 + ID_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RUN,
        S_COMPLETE,
        S_ERROR
    } state_t;

    state_t            state;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [2:0]        act_en;
    logic [ID_W-1:0]   act_id;
    logic              act_last;

    logic full;
    logic push;
    logic pop;
    logic tmo_hit;
    logic flush;
    logic active;
    logic [EW-1:0] head;

    assign full    = (count == CW'(DEPTH));
    assign push    = cmd_valid && cmd_ready;
    assign pop     = (state == S_IDLE) && (count != '0);
    assign tmo_hit = (timeout_limit != '0) && (tmo_cnt == timeout_limit - TMO_W'(1));
    // done_tpu has priority over a timeout landing in the same RUN cycle
    assign flush   = (state == S_RUN) && !done_tpu && tmo_hit;
    assign head    = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_en, cmd_id, cmd_last};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tmo_cnt  <= '0;
            act_en   <= '0;
            act_id   <= '0;
            act_last <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_next(wr_ptr);
                if (pop)  rd_ptr <= ptr_next(rd_ptr);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {act_en, act_id, act_last} <= head;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_CLR;
                S_CLR: begin
                    tmo_cnt <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (done_tpu)     state <= S_COMPLETE;
                    else if (tmo_hit) state <= S_ERROR;
                end
                S_COMPLETE: state <= S_IDLE;
                S_ERROR:    state <= S_ERROR;
                default:    state <= S_IDLE;
            endcase
        end
    end

    assign active            = (state == S_LOAD) || (state == S_CLR) ||
                               (state == S_RUN)  || (state == S_COMPLETE);
    assign timeout_err       = (state == S_ERROR);
    assign cmd_ready         = !reset && !full && !timeout_err;
    assign tpu_reset         = (state == S_CLR) || (state == S_COMPLETE) || (state == S_ERROR);
    assign start_tpu         = (state == S_RUN);
    assign enable_matmul     = active;
    assign enable_norm       = active && act_en[2];
    assign enable_pool       = active && act_en[1];
    assign enable_activation = active && act_en[0];
    assign busy              = active;
    assign layer_done        = (state == S_COMPLETE);
    assign layer_done_id     = layer_done ? act_id : '0;
    assign seq_done          = layer_done && act_last;

endmodule
